arp_rx_parser: RTL and testbench
================================

Name: arp_rx_parser

Overview:
- Parametrised ARP request/reply deserializer. Collects a 28-byte Ethernet/IPv4 ARP payload from a valid/ready word stream of configurable width and unpacks it into header fields.
- Validates frame length and header format, then presents one result record under a valid/ready output handshake.
- Sits between the MAC receive/EtherType demux (EtherType 0x0806 payload) and the ARP responder/cache logic.

Parameters:
- DATA_W, 32, input word width in bits; legal values 8, 16, 32; any other value is a static error (elaboration $error).
- BEATS, 224/DATA_W, localparam, beats per well-formed frame (28/14/7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_data  in  DATA_W  payload word; first byte on wire in MSBs
- s_valid  in  1  s_data valid
- s_last  in  1  final word of frame
- s_ready  out  1  parser accepts word
- hdr_type  out  16  HTYPE
- proto_type  out  16  PTYPE
- hdw_length  out  8  HLEN
- pro_length  out  8  PLEN
- operation  out  16  OPER
- send_hdr_addr  out  48  SHA
- send_ip_addr  out  32  SPA
- target_hdr_addr  out  48  THA
- target_ip_addr  out  32  TPA
- err_code  out  2  0=ok, 1=short, 2=long, 3=format
- m_valid  out  1  record valid
- m_ready  in  1  downstream accepts record

Behaviour:
- Beat accepted when s_valid && s_ready. s_ready = 1 in COLLECT and DRAIN, 0 in HOLD.
- 224-bit shift register; each accepted beat shifts in at the LSB end.
- Beat counter, width clog2(BEATS+1), cleared on frame end.
- Fields map from the register in network order: [223:208] HTYPE … [31:0] TPA.
- States:
  - COLLECT: accept beats.
    - s_last on beat index < BEATS-1: left-align the partial data (unfilled LSBs = 0), err=1, go to HOLD.
    - Beat index BEATS-1 with s_last: go to HOLD with err = format check.
    - Beat index BEATS-1 without s_last: go to DRAIN.
  - DRAIN: discard beats, register unchanged; on s_last go to HOLD with err=2.
  - HOLD: m_valid=1; fields and err_code stable. On m_ready go to COLLECT with counter 0. s_ready rises the cycle after the handshake (no same-cycle bypass).
- Format check: err=3 if HTYPE≠0x0001, PTYPE≠0x0800, HLEN≠6, or PLEN≠4. Priority: short/long over format.
- Latency: m_valid asserts the first cycle after the final accepted beat.
- Field outputs update only on entry to HOLD and hold their value otherwise.
- s_valid=0 gaps are allowed anywhere; the counter does not advance.
- Reset (including mid-frame or in HOLD): state COLLECT, counter 0, register 0, all field outputs 0, err_code 0, m_valid 0, s_ready 1 from the first cycle after reset deasserts. A partial frame is discarded.
- Single-beat frame with s_last on beat 0: short error (BEATS>1 for all legal DATA_W).

Optional Feature:
- Macro ARP_PARSER_STATS_EN.
- When defined, adds outputs frame_cnt (16) and err_cnt (16), both reset to 0:
  - frame_cnt increments on each HOLD entry.
  - err_cnt increments on each HOLD entry with err≠0.
  - Both saturate at 0xFFFF.
- When undefined, neither port nor counters exist; all other behaviour is identical.

Test Plan:
- DATA_W=32, 7 back-to-back beats 0x00010800, 0x06040001, 0xAABBCCDD, 0xEEFF0A00, 0x0001FFFF, 0xFFFFFFFF, 0x0A000002 (last on 7th), m_ready=1 → one cycle later m_valid=1, err=0, SHA=0xAABBCCDDEEFF, SPA=0x0A000001, THA=0xFFFFFFFFFFFF, TPA=0x0A000002, OPER=1.
- Same frame with m_ready=0 for 5 cycles, then s_valid held high with the next frame → s_ready=0 and outputs stable throughout HOLD; second frame accepted starting the cycle after the m_ready handshake.
- s_last on beat 4 → err=1, m_valid, TPA=0. Frame of 9 beats → beats 8–9 dropped, err=2, fields from the first 7 beats.
- First word 0x00060800 (HTYPE=6) → err=3. DATA_W=8 with the same 28 bytes fed one byte per beat with random s_valid gaps → same fields as scenario 1.
- rst pulsed after beat 3, then a clean frame → all outputs 0 after reset, clean frame decoded correctly with err=0. With ARP_PARSER_STATS_EN: after 3 good + 2 bad frames, frame_cnt=5, err_cnt=2.

Source files
------------

// File: rtl/arp_rx_parser.sv
// arp_rx_parser
//   Deserialises a 28-byte Ethernet/IPv4 ARP payload from a word stream and
//   unpacks it into header fields. It also checks the frame length and the
//   header format, then presents one result record downstream.
//
// Optional feature: define ARP_PARSER_STATS_EN to add the saturating
//   frame_cnt / err_cnt statistics outputs.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready   input word stream (first wire byte in MSBs)
//   hdr_type .. target_ip_addr      decoded ARP fields (stable while m_valid)
//   err_code          0=ok, 1=short, 2=long, 3=format
//   m_valid/m_ready   output record handshake
//   frame_cnt/err_cnt statistics (ARP_PARSER_STATS_EN only)
//   o_dbg_state       current FSM state (0=COLLECT, 1=DRAIN, 2=HOLD)
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
//   both high. A source holds valid and its payload until that edge. Ready is
//   a pure function of registered state, so there is no combinational path
//   from valid to ready.
module arp_rx_parser #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [15:0]       hdr_type,
  output logic [15:0]       proto_type,
  output logic [7:0]        hdw_length,
  output logic [7:0]        pro_length,
  output logic [15:0]       operation,
  output logic [47:0]       send_hdr_addr,
  output logic [31:0]       send_ip_addr,
  output logic [47:0]       target_hdr_addr,
  output logic [31:0]       target_ip_addr,
  output logic [1:0]        err_code,
`ifdef ARP_PARSER_STATS_EN
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt,
`endif
  output logic              m_valid,
  input  logic              m_ready,
  output logic [1:0]        o_dbg_state
);

  localparam int BEATS = 224 / DATA_W;
  localparam int CNT_W = $clog2(BEATS + 1);

  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_width
    $error("arp_rx_parser: DATA_W must be 8, 16 or 32");
  end

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DRAIN   = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [223:0]   r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [223:0]   w_shift_next;
  logic [223:0]   w_left;
  logic [223:0]   w_frame;
  logic [7:0]     w_shamt;
  logic           w_last_idx;
  logic           w_fmt_bad;
  logic           w_load;
  logic [1:0]     w_err;

  assign w_shift_next = {r_shift[223-DATA_W:0], s_data};
  assign w_last_idx   = (r_cnt == CNT_W'(BEATS - 1));

  // A short frame is left-aligned so that its received bytes land in their
  // network-order field positions; the missing tail reads as zero.
  assign w_shamt = 8'(DATA_W) * (8'(BEATS - 1) - 8'(r_cnt));
  assign w_left  = w_shift_next << w_shamt;

  // Format check applies only to a complete frame, so it looks at the word
  // that completes the register.
  assign w_fmt_bad = (w_shift_next[223:208] != 16'h0001) ||
                     (w_shift_next[207:192] != 16'h0800) ||
                     (w_shift_next[191:184] != 8'd6)     ||
                     (w_shift_next[183:176] != 8'd4);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_COLLECT;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_err        = 2'd0;
    w_frame      = w_shift_next;
    s_ready      = (r_state != S_HOLD);
    m_valid      = (r_state == S_HOLD);
    case (r_state)
      S_COLLECT: begin
        if (s_valid) begin
          if (w_last_idx) begin
            if (s_last) begin
              w_state_next = S_HOLD;
              w_load       = 1'b1;
              w_err        = w_fmt_bad ? 2'd3 : 2'd0;
            end else begin
              w_state_next = S_DRAIN;
            end
          end else if (s_last) begin
            w_state_next = S_HOLD;
            w_load       = 1'b1;
            w_err        = 2'd1;
            w_frame      = w_left;
          end
        end
      end
      S_DRAIN: begin
        // Over-long frame: the register already holds the first BEATS words.
        w_frame = r_shift;
        if (s_valid && s_last) begin
          w_state_next = S_HOLD;
          w_load       = 1'b1;
          w_err        = 2'd2;
        end
      end
      S_HOLD: begin
        if (m_ready) w_state_next = S_COLLECT;
      end
      default: w_state_next = S_COLLECT;
    endcase
  end

  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift         <= '0;
      r_cnt           <= '0;
      hdr_type        <= '0;
      proto_type      <= '0;
      hdw_length      <= '0;
      pro_length      <= '0;
      operation       <= '0;
      send_hdr_addr   <= '0;
      send_ip_addr    <= '0;
      target_hdr_addr <= '0;
      target_ip_addr  <= '0;
      err_code        <= '0;
    end else begin
      if (r_state == S_COLLECT && s_valid) begin
        r_shift <= w_frame;
        if (s_last || w_last_idx) r_cnt <= '0;
        else                      r_cnt <= r_cnt + 1'b1;
      end
      if (w_load) begin
        hdr_type        <= w_frame[223:208];
        proto_type      <= w_frame[207:192];
        hdw_length      <= w_frame[191:184];
        pro_length      <= w_frame[183:176];
        operation       <= w_frame[175:160];
        send_hdr_addr   <= w_frame[159:112];
        send_ip_addr    <= w_frame[111:80];
        target_hdr_addr <= w_frame[79:32];
        target_ip_addr  <= w_frame[31:0];
        err_code        <= w_err;
      end
    end
  end

`ifdef ARP_PARSER_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (w_load) begin
      if (r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_err != 2'd0 && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_arp_rx_parser.sv
module tb_arp_rx_parser;

  typedef struct {
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
    logic [1:0]  err;
  } fields_t;

  typedef struct {
    logic [0:9][31:0] words;
    int               n;
    fields_t          exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT, DATA_W = 32 ----------------
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [15:0] hdr_type, proto_type, operation;
  logic [7:0]  hdw_length, pro_length;
  logic [47:0] send_hdr_addr, target_hdr_addr;
  logic [31:0] send_ip_addr, target_ip_addr;
  logic [1:0]  err_code, dbg_state;
  logic        m_valid, m_ready = 1'b1;
`ifdef ARP_PARSER_STATS_EN
  logic [15:0] frame_cnt, err_cnt, frame_cnt8, err_cnt8;
`endif

  arp_rx_parser #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .hdr_type(hdr_type), .proto_type(proto_type),
    .hdw_length(hdw_length), .pro_length(pro_length), .operation(operation),
    .send_hdr_addr(send_hdr_addr), .send_ip_addr(send_ip_addr),
    .target_hdr_addr(target_hdr_addr), .target_ip_addr(target_ip_addr),
    .err_code(err_code),
`ifdef ARP_PARSER_STATS_EN
    .frame_cnt(frame_cnt), .err_cnt(err_cnt),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .o_dbg_state(dbg_state)
  );

  // ---------------- DUT, DATA_W = 8 ----------------
  logic [7:0]  s8_data = '0;
  logic        s8_valid = 1'b0, s8_last = 1'b0, s8_ready;
  logic [15:0] hdr_type8, proto_type8, operation8;
  logic [7:0]  hdw_length8, pro_length8;
  logic [47:0] send_hdr_addr8, target_hdr_addr8;
  logic [31:0] send_ip_addr8, target_ip_addr8;
  logic [1:0]  err_code8, dbg_state8;
  logic        m_valid8, m8_ready = 1'b1;

  arp_rx_parser #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst),
    .s_data(s8_data), .s_valid(s8_valid), .s_last(s8_last), .s_ready(s8_ready),
    .hdr_type(hdr_type8), .proto_type(proto_type8),
    .hdw_length(hdw_length8), .pro_length(pro_length8), .operation(operation8),
    .send_hdr_addr(send_hdr_addr8), .send_ip_addr(send_ip_addr8),
    .target_hdr_addr(target_hdr_addr8), .target_ip_addr(target_ip_addr8),
    .err_code(err_code8),
`ifdef ARP_PARSER_STATS_EN
    .frame_cnt(frame_cnt8), .err_cnt(err_cnt8),
`endif
    .m_valid(m_valid8), .m_ready(m8_ready), .o_dbg_state(dbg_state8)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [1:0] exp_q[$];

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_fields(input string tag, input fields_t a, input fields_t e);
    check_val({tag, ".htype"}, 64'(a.htype), 64'(e.htype));
    check_val({tag, ".ptype"}, 64'(a.ptype), 64'(e.ptype));
    check_val({tag, ".hlen"},  64'(a.hlen),  64'(e.hlen));
    check_val({tag, ".plen"},  64'(a.plen),  64'(e.plen));
    check_val({tag, ".oper"},  64'(a.oper),  64'(e.oper));
    check_val({tag, ".sha"},   64'(a.sha),   64'(e.sha));
    check_val({tag, ".spa"},   64'(a.spa),   64'(e.spa));
    check_val({tag, ".tha"},   64'(a.tha),   64'(e.tha));
    check_val({tag, ".tpa"},   64'(a.tpa),   64'(e.tpa));
    check_val({tag, ".err"},   64'(a.err),   64'(e.err));
  endtask

  function automatic fields_t get32();
    fields_t f;
    f.htype = hdr_type;      f.ptype = proto_type;
    f.hlen  = hdw_length;    f.plen  = pro_length;
    f.oper  = operation;     f.sha   = send_hdr_addr;
    f.spa   = send_ip_addr;  f.tha   = target_hdr_addr;
    f.tpa   = target_ip_addr; f.err  = err_code;
    return f;
  endfunction

  function automatic fields_t get8();
    fields_t f;
    f.htype = hdr_type8;      f.ptype = proto_type8;
    f.hlen  = hdw_length8;    f.plen  = pro_length8;
    f.oper  = operation8;     f.sha   = send_hdr_addr8;
    f.spa   = send_ip_addr8;  f.tha   = target_hdr_addr8;
    f.tpa   = target_ip_addr8; f.err  = err_code8;
    return f;
  endfunction

  // ---------------- drivers ----------------
  // Returns at (accepting edge + 1). s_ready only changes on clk edges, so the
  // value seen at the preceding negedge is the one the DUT uses at the edge.
  task automatic wait_accept32();
    int   t = 0;
    logic ok;
    forever begin
      @(negedge clk); ok = s_ready;
      @(posedge clk); #1;
      if (ok) break;
      t++;
      if (t > 50) begin
        n_vec++; n_miss++;
        $display("FAIL accept32_timeout: got no s_ready, expected s_ready within 50 cycles");
        break;
      end
    end
  endtask

  task automatic wait_accept8();
    int   t = 0;
    logic ok;
    forever begin
      @(negedge clk); ok = s8_ready;
      @(posedge clk); #1;
      if (ok) break;
      t++;
      if (t > 50) begin
        n_vec++; n_miss++;
        $display("FAIL accept8_timeout: got no s_ready, expected s_ready within 50 cycles");
        break;
      end
    end
  endtask

  task automatic send32(input logic [0:9][31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      s_data = w[i]; s_valid = 1'b1; s_last = (i == n - 1);
      wait_accept32();
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send8_gappy(input logic [223:0] flat);
    for (int i = 0; i < 28; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      s8_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      s8_data = flat[223 - 8*i -: 8]; s8_valid = 1'b1; s8_last = (i == 27);
      wait_accept8();
    end
    s8_valid = 1'b0; s8_last = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [0:9][31:0] fa, fb;
  fields_t ea, eb, ez;
  vec_t    vecs[9];
  logic [223:0] flat_a;

  initial begin
    fa = {32'h00010800, 32'h06040001, 32'hAABBCCDD, 32'hEEFF0A00,
          32'h0001FFFF, 32'hFFFFFFFF, 32'h0A000002, 32'h0, 32'h0, 32'h0};
    fb = {32'h00010800, 32'h06040002, 32'h11223344, 32'h55660A00,
          32'h0002A1A2, 32'hA3A4A5A6, 32'h0A000001, 32'h0, 32'h0, 32'h0};
    ea = '{htype:16'h0001, ptype:16'h0800, hlen:8'h06, plen:8'h04, oper:16'h0001,
           sha:48'hAABBCCDDEEFF, spa:32'h0A000001, tha:48'hFFFFFFFFFFFF,
           tpa:32'h0A000002, err:2'd0};
    eb = '{htype:16'h0001, ptype:16'h0800, hlen:8'h06, plen:8'h04, oper:16'h0002,
           sha:48'h112233445566, spa:32'h0A000002, tha:48'hA1A2A3A4A5A6,
           tpa:32'h0A000001, err:2'd0};
    ez = '{htype:16'h0, ptype:16'h0, hlen:8'h0, plen:8'h0, oper:16'h0,
           sha:48'h0, spa:32'h0, tha:48'h0, tpa:32'h0, err:2'd0};
    flat_a = {fa[0], fa[1], fa[2], fa[3], fa[4], fa[5], fa[6]};

    // 0: clean request
    vecs[0].words = fa; vecs[0].n = 7; vecs[0].exp = ea;
    // 1: s_last on 4th beat -> short, tail zero
    vecs[1].words = fa; vecs[1].n = 4; vecs[1].exp = ea;
    vecs[1].exp.spa = 32'h0A000000; vecs[1].exp.tha = 48'h0; vecs[1].exp.tpa = 32'h0;
    vecs[1].exp.err = 2'd1;
    // 2: nine beats -> long, fields from first seven
    vecs[2].words = fa; vecs[2].words[7] = 32'h12345678; vecs[2].words[8] = 32'h9ABCDEF0;
    vecs[2].n = 9; vecs[2].exp = ea; vecs[2].exp.err = 2'd2;
    // 3: HTYPE = 6 -> format
    vecs[3].words = fa; vecs[3].words[0] = 32'h00060800; vecs[3].n = 7;
    vecs[3].exp = ea; vecs[3].exp.htype = 16'h0006; vecs[3].exp.err = 2'd3;
    // 4: clean reply
    vecs[4].words = fb; vecs[4].n = 7; vecs[4].exp = eb;
    // 5: single-beat frame -> short
    vecs[5].words = fa; vecs[5].n = 1; vecs[5].exp = ez;
    vecs[5].exp.htype = 16'h0001; vecs[5].exp.ptype = 16'h0800; vecs[5].exp.err = 2'd1;
    // 6: one beat short of full
    vecs[6].words = fa; vecs[6].n = 6; vecs[6].exp = ea;
    vecs[6].exp.tpa = 32'h0; vecs[6].exp.err = 2'd1;
    // 7: one beat too many
    vecs[7].words = fb; vecs[7].words[7] = 32'hDEADBEEF; vecs[7].n = 8;
    vecs[7].exp = eb; vecs[7].exp.err = 2'd2;
    // 8: PLEN = 5 -> format
    vecs[8].words = fa; vecs[8].words[1] = 32'h06050001; vecs[8].n = 7;
    vecs[8].exp = ea; vecs[8].exp.plen = 8'h05; vecs[8].exp.err = 2'd3;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check_val("rst.m_valid", 64'(m_valid), 64'd0);
    check_val("rst.s_ready", 64'(s_ready), 64'd1);
    check_fields("rst32", get32(), ez);
    check_val("rst.m_valid8", 64'(m_valid8), 64'd0);
    check_fields("rst8", get8(), ez);
`ifdef ARP_PARSER_STATS_EN
    check_val("rst.frame_cnt", 64'(frame_cnt), 64'd0);
    check_val("rst.err_cnt", 64'(err_cnt), 64'd0);
`endif

    // table-driven vectors, m_ready held high
    m_ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      exp_q.push_back(vecs[v].exp.err);
      send32(vecs[v].words, vecs[v].n);
      check_val($sformatf("vec%0d.m_valid", v), 64'(m_valid), 64'd1);
      check_fields($sformatf("vec%0d", v), get32(), vecs[v].exp);
      check_val($sformatf("vec%0d.err_q", v), 64'(err_code), 64'(exp_q.pop_front()));
      @(posedge clk); #1;
      check_val($sformatf("vec%0d.m_valid_clr", v), 64'(m_valid), 64'd0);
    end

    // backpressure: HOLD for 5 cycles with the next frame waiting
    m_ready = 1'b0;
    send32(fa, 7);
    check_val("bp.m_valid", 64'(m_valid), 64'd1);
    s_data = fb[0]; s_valid = 1'b1; s_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val($sformatf("bp%0d.s_ready", c), 64'(s_ready), 64'd0);
      check_val($sformatf("bp%0d.m_valid", c), 64'(m_valid), 64'd1);
      check_fields($sformatf("bp%0d", c), get32(), ea);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    check_val("bp.hs_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    check_val("bp.after_m_valid", 64'(m_valid), 64'd0);
    check_val("bp.after_s_ready", 64'(s_ready), 64'd1);
    send32(fb, 7);
    check_val("bp2.m_valid", 64'(m_valid), 64'd1);
    check_fields("bp2", get32(), eb);
    @(posedge clk); #1;

    // reset after 3 beats of a frame, then a clean frame
    for (int i = 0; i < 3; i++) begin
      s_data = fa[i]; s_valid = 1'b1; s_last = 1'b0;
      wait_accept32();
    end
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("rst2.m_valid", 64'(m_valid), 64'd0);
    check_val("rst2.s_ready", 64'(s_ready), 64'd1);
    check_fields("rst2", get32(), ez);
    send32(fa, 7);
    check_val("rst2_frame.m_valid", 64'(m_valid), 64'd1);
    check_fields("rst2_frame", get32(), ea);
    @(posedge clk); #1;

`ifdef ARP_PARSER_STATS_EN
    // one good frame so far since reset; add 2 good + 2 bad
    send32(fa, 7); @(posedge clk); #1;
    send32(fb, 7); @(posedge clk); #1;
    send32(vecs[3].words, 7); @(posedge clk); #1;
    send32(fa, 4); @(posedge clk); #1;
    check_val("stats.frame_cnt", 64'(frame_cnt), 64'd5);
    check_val("stats.err_cnt", 64'(err_cnt), 64'd2);
`endif

    // DATA_W = 8, same 28 bytes with random gaps
    send8_gappy(flat_a);
    check_val("w8.m_valid", 64'(m_valid8), 64'd1);
    check_fields("w8", get8(), ea);
    @(posedge clk); #1;
    check_val("w8.m_valid_clr", 64'(m_valid8), 64'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
